serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
Parallel-to-serial frame transmitter that drives a single-bit line, the `d` stream into the dff chain and the DFF-based receivers.
- Accepts a DATA_W-bit word on a valid/ready handshake.
- Sends it LSB-first inside a start/stop frame, each bit held for CLKS_PER_BIT clocks.
- Sits between the test stimulus generator (or a host block) and any single-bit serial sink in the design.

Parameters:
DATA_W, 8, payload width in bits (>=1)
CLKS_PER_BIT, 4, clock cycles each line bit is held (>=1; elaboration-time error if 0)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
din  input  DATA_W  word to transmit, sampled only at handshake
din_valid  input  1  producer has a word on din
din_ready  output  1  block can accept a word (high only in IDLE)
tx  output  1  serial line, idle high
busy  output  1  high while a frame is in progress (START/DATA/STOP)
done  output  1  one-cycle pulse in final STOP cycle

Behaviour:
Interface (decided):
- One clock, clk.
- Reset rst is asynchronous and active-high.

Reset (asynchronous, immediate, overrides everything):
- State = IDLE, tx=1, din_ready=1, busy=0, done=0.
- Shift register, bit counter and baud counter cleared.

Handshake:
- Transfer occurs on a rising edge where din_valid && din_ready.
- din is captured into the shift register at that edge; later changes on din are ignored.
- din_valid may be held high while busy. No transfer, no side effect.
- din_valid need not drop after a transfer. If it is still high in the next IDLE cycle, that is a new transfer.

FSM:
- IDLE: tx=1, din_ready=1, busy=0. On transfer -> START.
- START: tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA:
  - tx = shift_reg[0], held CLKS_PER_BIT cycles per bit, then shift right.
  - After DATA_W bits -> STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - done=1 in the last of these cycles only.
  - Then -> IDLE.

Outputs and timing:
- din_ready = (state==IDLE).
- busy = (state!=IDLE).
- tx and done are registered outputs (no combinational path from inputs).
- Timing, with the transfer at edge k:
  - tx=0 from edge k to edge k+CLKS_PER_BIT.
  - Frame occupies (DATA_W+2)*CLKS_PER_BIT cycles.
  - done is high between edges k+F-1 and k+F, where F is the frame length.
  - din_ready is high again from edge k+F.
- Minimum spacing of back-to-back transfers is F+1 edges.

Counters:
- Baud counter: $clog2(CLKS_PER_BIT) bits (min 1). Counts 0..CLKS_PER_BIT-1, wraps, and produces a bit_tick at terminal count.
- Bit counter: $clog2(DATA_W+1) bits. Counts bits sent in DATA.
- Both counters are cleared on entry to each state.
- For CLKS_PER_BIT=1, bit_tick is asserted every cycle.

Reset mid-frame:
- tx returns to 1 at once and the frame is abandoned.
- No done pulse for the abandoned frame.
- No word is retained.

Decomposition:
Package serial_tx_pkg:
- State enum tx_state_e {IDLE, START, DATA, STOP}.
- Localparam function for the frame length F = (DATA_W+2)*CLKS_PER_BIT, used by RTL and bench.

Sub-module serial_tx_baud:
- Parameterised baud counter.
- Inputs: clk, rst, clear, enable.
- Output: bit_tick.

Interface:
- Add serial_tx_if (clk, rst, din, din_valid, din_ready, tx, busy, done) for the test bench environment.

Test Plan:
All scenarios use DATA_W=8, CLKS_PER_BIT=4 (F=40) unless noted.
1. Reset: rst=1 for 10 time units with din_valid=1 -> tx=1, din_ready=1, busy=0, done=0 throughout; no transfer.
2. Send 0xA5 at edge k:
   - tx=0 for edges k..k+4.
   - Then tx bits 1,0,1,0,0,1,0,1, each 4 cycles.
   - tx=1 stop bit for edges k+36..k+40.
   - done=1 only between edges k+39 and k+40; din_ready=1 from edge k+40.
3. din_valid held high with din=0x3C, changed to 0xFF mid-frame -> exactly one frame carrying 0x3C. A second frame starts at edge k+41 carrying the din present then.
4. rst asserted during DATA bit 3 of 0x5A:
   - tx=1 asynchronously; busy=0; no done pulse.
   - After release, a 0x81 transfer produces a correct, complete 40-cycle frame.
5. Edge patterns: 0x00 gives tx low for 36 cycles then high for 4; 0xFF gives low for 4 then high for 36.
6. CLKS_PER_BIT=1 build, 0xC3 -> 10-cycle frame 0,1,1,0,0,0,0,1,1,1; done in cycle 10.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial frame transmitter.
package serial_tx_pkg;

  // Line phases of one frame; IDLE holds the line high between frames.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Clocks occupied by one frame: start bit, DATA_W payload bits, stop bit.
  function automatic int frame_len(input int data_w, input int clks_per_bit);
    return (data_w + 2) * clks_per_bit;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Signal bundle for hooking serial_tx into a bench or host environment.
interface serial_tx_if #(
  parameter int DATA_W = 8
) (
  input logic clk
);
  logic              rst;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              tx;
  logic              busy;
  logic              done;
endinterface

// File: rtl/serial_tx_baud.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// tick_ahead reports that the count after the coming edge is terminal,
// which lets the parent register outputs aligned to the last bit cycle.
module serial_tx_baud
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_tick,
  output logic tick_ahead
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 1) begin : g_bad_clks
      $error("serial_tx_baud: CLKS_PER_BIT must be at least 1");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise advance and wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = bit_tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick   = (cnt_q == LAST);
  assign tick_ahead = (cnt_d == LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start bit (0), DATA_W bits LSB
// first, stop bit (1), each held CLKS_PER_BIT clocks.
//
// Handshake: a word transfers on a rising edge where din_valid && din_ready.
// din_ready is high only in IDLE; din is captured at that edge and ignored
// afterwards. din_valid may stay high while busy with no effect, and if it
// is still high in the following IDLE cycle that starts a new transfer.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int BCNT_W = $clog2(DATA_W + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

  generate
    if (DATA_W < 1) begin : g_bad_width
      $error("serial_tx: DATA_W must be at least 1");
    end
  endgenerate

  tx_state_e         state_q;
  tx_state_e         state_d;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [BCNT_W-1:0] bit_cnt_q;
  logic [BCNT_W-1:0] bit_cnt_d;
  logic              tx_d;
  logic              done_d;
  logic              xfer;
  logic              bit_tick;
  logic              tick_ahead;
  logic              baud_clear;
  logic              baud_enable;

  assign xfer = din_valid && (state_q == IDLE);

  // Baud counter restarts on every state entry and idles at zero.
  assign baud_clear  = (state_d != state_q) || (state_q == IDLE);
  assign baud_enable = (state_q != IDLE);

  serial_tx_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .clear     (baud_clear),
    .enable    (baud_enable),
    .bit_tick  (bit_tick),
    .tick_ahead(tick_ahead)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each phase ends on the baud terminal count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (xfer) state_d = START;
      START: if (bit_tick) state_d = DATA;
      DATA:  if (bit_tick && (bit_cnt_q == LAST_BIT)) state_d = STOP;
      STOP:  if (bit_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: handshake/status from the current state, and the next values
  // of the registered line and done flag from the next state.
  always_comb begin
    din_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    dbg_state = state_q;
    tx_d      = 1'b1;
    done_d    = 1'b0;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      STOP:    done_d = tick_ahead;
      default: tx_d = 1'b1;
    endcase
  end

  // Datapath next values: capture on transfer, shift after each data bit,
  // bit counter restarts on every state entry.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (xfer) begin
      shift_d = din;
    end else if ((state_q == DATA) && bit_tick) begin
      shift_d = shift_q >> 1;
    end
    if (state_d != state_q) begin
      bit_cnt_d = '0;
    end else if ((state_q == DATA) && bit_tick) begin
      bit_cnt_d = bit_cnt_q + BCNT_W'(1);
    end
  end

  // Datapath and registered outputs; reset drops any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx        <= 1'b1;
      done      <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx        <= tx_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: main instance DATA_W=8/CLKS_PER_BIT=4 and a
// second instance with CLKS_PER_BIT=1.
module tb_serial_tx;
  import serial_tx_pkg::*;

  localparam int F  = frame_len(8, 4);
  localparam int F1 = frame_len(8, 1);

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  serial_tx_if #(.DATA_W(8)) bus (.clk(clk));
  logic [1:0] dbg_state;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
    .clk      (clk),
    .rst      (bus.rst),
    .din      (bus.din),
    .din_valid(bus.din_valid),
    .din_ready(bus.din_ready),
    .tx       (bus.tx),
    .busy     (bus.busy),
    .done     (bus.done),
    .dbg_state(dbg_state)
  );

  logic       rst1;
  logic [7:0] din1;
  logic       din_valid1;
  logic       din_ready1;
  logic       tx1;
  logic       busy1;
  logic       done1;
  logic [1:0] dbg_state1;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .clk      (clk),
    .rst      (rst1),
    .din      (din1),
    .din_valid(din_valid1),
    .din_ready(din_ready1),
    .tx       (tx1),
    .busy     (busy1),
    .done     (done1),
    .dbg_state(dbg_state1)
  );

  // ---------------- driver tasks ----------------
  logic       tx_log[64];
  logic       done_log[64];
  logic       busy_log[64];
  logic       ready_log[64];
  logic [1:0] state_log[64];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word; returns 1 ns after the transfer edge.
  task automatic send(input logic [7:0] word, input logic keep_valid);
    bus.din       = word;
    bus.din_valid = 1'b1;
    step();
    bus.din_valid = keep_valid;
    if (!keep_valid) bus.din = 8'h00;
  endtask

  // Record n cycles of the main instance; optionally change din at one cycle.
  task automatic capture_frame(input int n, input int change_at, input logic [7:0] change_val);
    for (int j = 0; j < n; j++) begin
      tx_log[j]    = bus.tx;
      done_log[j]  = bus.done;
      busy_log[j]  = bus.busy;
      ready_log[j] = bus.din_ready;
      state_log[j] = dbg_state;
      if (j == change_at) bus.din = change_val;
      step();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] obs;
    bus.rst = 1'b1;  bus.din = 8'hA5;  bus.din_valid = 1'b1;
    rst1    = 1'b1;  din1    = 8'h00;  din_valid1    = 1'b0;
    for (int t = 0; t < 3; t++) begin
      #3;
      obs = {4'b0, bus.tx, bus.din_ready, bus.busy, bus.done};
      checks++;
      if (obs !== 8'b0000_1100) begin
        errors++;
        $display("FAIL reset_outputs t=%0t: got tx,ready,busy,done=%b expected 1100", $time, obs[3:0]);
      end
    end
    #1;
    bus.rst = 1'b0;  bus.din_valid = 1'b0;  rst1 = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.tx !== 1'b1 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_no_transfer: got busy=%b tx=%b state=%0d expected 0 1 0", bus.busy, bus.tx, dbg_state);
    end
  endtask

  task automatic test_frame_a5();
    logic [9:0] line;
    line = 10'b1101001010;
    send(8'hA5, 1'b0);
    capture_frame(F, -1, 8'h00);
    for (int j = 0; j < F; j++) begin
      checks++;
      if (tx_log[j] !== line[j/4]) begin
        errors++;
        $display("FAIL a5_tx cycle %0d: got %b expected %b", j, tx_log[j], line[j/4]);
      end
      checks++;
      if (done_log[j] !== (j == F - 1) || busy_log[j] !== 1'b1 || ready_log[j] !== 1'b0) begin
        errors++;
        $display("FAIL a5_status cycle %0d: got done=%b busy=%b ready=%b expected %b 1 0",
                 j, done_log[j], busy_log[j], ready_log[j], (j == F - 1));
      end
    end
    checks++;
    if (state_log[0] !== 2'd1 || state_log[4] !== 2'd2 || state_log[35] !== 2'd2 || state_log[36] !== 2'd3) begin
      errors++;
      $display("FAIL a5_states: got %0d %0d %0d %0d expected 1 2 2 3",
               state_log[0], state_log[4], state_log[35], state_log[36]);
    end
    checks++;
    if (bus.din_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tx !== 1'b1) begin
      errors++;
      $display("FAIL a5_after: got ready=%b busy=%b done=%b tx=%b expected 1 0 0 1",
               bus.din_ready, bus.busy, bus.done, bus.tx);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] line;
    line = 10'b1001111000;
    send(8'h3C, 1'b1);
    capture_frame(F, 20, 8'hFF);
    for (int j = 0; j < F; j++) begin
      checks++;
      if (tx_log[j] !== line[j/4] || done_log[j] !== (j == F - 1)) begin
        errors++;
        $display("FAIL b2b_first cycle %0d: got tx=%b done=%b expected %b %b",
                 j, tx_log[j], done_log[j], line[j/4], (j == F - 1));
      end
    end
    checks++;
    if (bus.din_ready !== 1'b1 || bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: got ready=%b busy=%b tx=%b expected 1 0 1", bus.din_ready, bus.busy, bus.tx);
    end
    step();
    bus.din_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.tx !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_start: got busy=%b tx=%b expected 1 0", bus.busy, bus.tx);
    end
    line = 10'b1111111110;
    capture_frame(F, -1, 8'h00);
    for (int j = 0; j < F; j++) begin
      checks++;
      if (tx_log[j] !== line[j/4] || done_log[j] !== (j == F - 1)) begin
        errors++;
        $display("FAIL b2b_second cycle %0d: got tx=%b done=%b expected %b %b",
                 j, tx_log[j], done_log[j], line[j/4], (j == F - 1));
      end
    end
    checks++;
    if (bus.din_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_after: got ready=%b busy=%b expected 1 0", bus.din_ready, bus.busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] line;
    send(8'h5A, 1'b0);
    for (int j = 0; j < 17; j++) step();
    checks++;
    if (dbg_state !== 2'd2 || bus.tx !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_before: got state=%0d tx=%b busy=%b expected 2 1 1", dbg_state, bus.tx, bus.busy);
    end
    #2;
    bus.rst = 1'b1;
    #1;
    checks++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.din_ready !== 1'b1 || bus.done !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL midrst_async: got tx=%b busy=%b ready=%b done=%b state=%0d expected 1 0 1 0 0",
               bus.tx, bus.busy, bus.din_ready, bus.done, dbg_state);
    end
    step();
    step();
    bus.rst = 1'b0;
    for (int j = 0; j < F; j++) begin
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
        errors++;
        $display("FAIL midrst_quiet cycle %0d: got done=%b busy=%b tx=%b expected 0 0 1", j, bus.done, bus.busy, bus.tx);
      end
      step();
    end
    line = 10'b1100000010;
    send(8'h81, 1'b0);
    capture_frame(F, -1, 8'h00);
    for (int j = 0; j < F; j++) begin
      checks++;
      if (tx_log[j] !== line[j/4] || done_log[j] !== (j == F - 1) || busy_log[j] !== 1'b1) begin
        errors++;
        $display("FAIL midrst_81 cycle %0d: got tx=%b done=%b busy=%b expected %b %b 1",
                 j, tx_log[j], done_log[j], busy_log[j], line[j/4], (j == F - 1));
      end
    end
  endtask

  task automatic test_edge_patterns();
    int lows;
    send(8'h00, 1'b0);
    capture_frame(F, -1, 8'h00);
    lows = 0;
    for (int j = 0; j < F; j++) if (tx_log[j] === 1'b0) lows++;
    checks++;
    if (lows !== 36 || tx_log[35] !== 1'b0 || tx_log[36] !== 1'b1 || tx_log[39] !== 1'b1) begin
      errors++;
      $display("FAIL pattern_00: got lows=%0d tx35=%b tx36=%b tx39=%b expected 36 0 1 1",
               lows, tx_log[35], tx_log[36], tx_log[39]);
    end
    send(8'hFF, 1'b0);
    capture_frame(F, -1, 8'h00);
    lows = 0;
    for (int j = 0; j < F; j++) if (tx_log[j] === 1'b0) lows++;
    checks++;
    if (lows !== 4 || tx_log[3] !== 1'b0 || tx_log[4] !== 1'b1 || done_log[39] !== 1'b1) begin
      errors++;
      $display("FAIL pattern_ff: got lows=%0d tx3=%b tx4=%b done39=%b expected 4 0 1 1",
               lows, tx_log[3], tx_log[4], done_log[39]);
    end
  endtask

  task automatic test_one_clk_per_bit();
    logic [9:0] line;
    logic [9:0] got_tx;
    logic [9:0] got_done;
    logic [11:0] got_busy;
    line = 10'b1110000110;
    din1 = 8'hC3;
    din_valid1 = 1'b1;
    step();
    din_valid1 = 1'b0;
    din1 = 8'h00;
    for (int j = 0; j < F1; j++) begin
      got_tx[j]   = tx1;
      got_done[j] = done1;
      step();
    end
    checks++;
    if (got_tx !== line) begin
      errors++;
      $display("FAIL clk1_tx: got %b expected %b (bit0 first)", got_tx, line);
    end
    checks++;
    if (got_done !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL clk1_done: got %b expected 1000000000", got_done);
    end
    checks++;
    if (din_ready1 !== 1'b1 || busy1 !== 1'b0 || dbg_state1 !== 2'd0) begin
      errors++;
      $display("FAIL clk1_after: got ready=%b busy=%b state=%0d expected 1 0 0", din_ready1, busy1, dbg_state1);
    end
    // Held valid: the next transfer lands F1+1 edges after the previous one.
    din1 = 8'h01;
    din_valid1 = 1'b1;
    step();
    for (int j = 0; j < 12; j++) begin
      got_busy[j] = busy1;
      step();
      if (j == 10) din_valid1 = 1'b0;
    end
    checks++;
    if (got_busy !== 12'b1011_1111_1111) begin
      errors++;
      $display("FAIL clk1_spacing: got busy %b expected 101111111111", got_busy);
    end
    for (int j = 0; j < 12; j++) step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_reset_mid_frame();
    test_edge_patterns();
    test_one_clk_per_bit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
